fft8_reorder: RTL and testbench
===============================

# fft8_reorder

Output reorder buffer for the 8-point pipelined FFT: accepts the two-lane, bit-reversed-order pairs produced by the last FFT stage and re-emits each frame as natural-order pairs on two lanes. Sits directly after the final stage/multiplier and is the consumer end of the stage L/U datapath. Uses ping-pong buffering so continuous frames stream without stalls.

## Interface
- DW, 14, signed sample width per real/imag component (matches stage output width)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat valid
- in_sof  in  1  first beat of a frame; qualified by in_valid
- LI_real, LI_imag  in  DW each  lower lane input (even-index bin)
- UI_real, UI_imag  in  DW each  upper lane input (odd-index bin)
- out_valid  out  1  output beat valid
- out_sof  out  1  first output beat of a frame
- LO_real, LO_imag  out  DW each  lower lane output, bin X[2j]
- UO_real, UO_imag  out  DW each  upper lane output, bin X[2j+1]
- sof_err  out  1  one-cycle pulse: frame truncated by early in_sof

## Operation
- Frame = 8 bins = 4 input beats. Input beat c (0..3) carries L = X[br3(c)], U = X[br3(c)+1], i.e. pair index p = br2(c): beat order p = 0,2,1,3.
- Output beat j (0..3) carries pair j: L = X[2j], U = X[2j+1].
- Write side: write counter wcnt (2 bits) and write-bank select wb. Beat accepted only when in_valid=1. After reset, beats are ignored until the first in_valid&in_sof (sync flag). in_sof with in_valid forces the beat to slot 0 of bank wb.
- Beat stored at address br2(wcnt) of bank wb. On acceptance of wcnt=3: bank wb marked full, wb toggles, wcnt wraps to 0.
- in_sof&in_valid while wcnt≠0: partial frame discarded (bank not marked full), beat written as slot 0 of same bank, sof_err pulses the next cycle.
- in_valid=1 with in_sof=0 while unsynced: ignored, no error.
- Read FSM: IDLE, READ. IDLE→READ when any bank full (oldest first; rb tracks it). READ emits addresses 0,1,2,3 on consecutive cycles, no gaps, no backpressure. After address 3: clear full of rb, toggle rb; if other bank full, stay in READ with rcnt=0 (back-to-back), else IDLE.
- Write of a bank still being read cannot occur at legal rates (≥4 cycles/frame write, exactly 4 read); no overflow handling required.
- Data pass-through unchanged; no arithmetic, no width change.

## Timing
- Reset values: out_valid=0, out_sof=0, sof_err=0, all LO/UO = 0; wcnt=0, wb=0, rb=0, both full flags 0, sync=0, FSM IDLE. Bank contents not reset.
- All outputs registered. LO/UO forced to 0 whenever out_valid=0.
- Latency: beat 3 presented in cycle t (captured at edge t). Output beat 0 (out_sof=1) valid in cycle t+2; beats 1–3 in t+3..t+5.
- Continuous input (beats every cycle): output continuous, out_sof every 4 cycles, first output 5 cycles after frame beat 0.
- Bank full set and read start on same edge: read proceeds from the earlier-filled bank.
- rst mid-frame or mid-read: immediate abort, all state to reset values, in-flight frames lost; resync required.

## Structure
- Shared package fft8_pkg: DW default, N_POINTS=8, N_PAIRS=4, br2 function (2-bit bit reverse), complex-pair struct typedef.
- One sub-module: fft8_pingpong_bank (2 banks × 4 addresses × 4 DW-bit fields, single write port, single read port, no reset on storage).
- Read FSM, write counter, full flags in top module.

## Test plan
- Single frame, beats LI_real = 0,4,2,6 / UI_real = 1,5,3,7 (imag = −real), in_sof on beat 0 -> out beats LO_real 0,2,4,6, UO_real 1,3,5,7, out_sof on first only, first output 2 cycles after beat 3.
- Three back-to-back frames, every cycle -> 12 consecutive out_valid cycles, out_sof every 4th, values of frame k offset by 100k correctly ordered.
- Gapped input (in_valid toggling 1,0,1,0…) -> same natural-order output, 4 contiguous output beats per frame.
- in_sof after 2 beats, then full frame -> sof_err pulses once, only the full frame emitted.
- Beats without prior in_sof after reset -> no out_valid; rst asserted during output beat 1 -> out_valid=0 and LO/UO=0 immediately, no further output until new synced frame.
- Extreme values: LI_real = −8192 (min DW=14), UI_imag = 8191 -> passed bit-exact.

Source files
------------

// File: rtl/fft8_pkg.sv
// Shared types and helpers for the 8-point FFT output reorder path.
package fft8_pkg;

  localparam int unsigned DW       = 14;
  localparam int unsigned N_POINTS = 8;
  localparam int unsigned N_PAIRS  = N_POINTS / 2;

  typedef logic [1:0] addr_t;

  typedef struct packed {
    logic signed [DW-1:0] l_real;
    logic signed [DW-1:0] l_imag;
    logic signed [DW-1:0] u_real;
    logic signed [DW-1:0] u_imag;
  } pair_t;

  typedef enum logic [0:0] {StIdle, StRead} rd_state_e;

  function automatic addr_t br2(input addr_t a);
    return {a[0], a[1]};
  endfunction

endpackage

// File: rtl/fft8_reorder_if.sv
// Two-lane pair stream into and out of the reorder buffer.
interface fft8_reorder_if;
  import fft8_pkg::*;

  logic                 in_valid;
  logic                 in_sof;
  logic signed [DW-1:0] LI_real;
  logic signed [DW-1:0] LI_imag;
  logic signed [DW-1:0] UI_real;
  logic signed [DW-1:0] UI_imag;
  logic                 out_valid;
  logic                 out_sof;
  logic signed [DW-1:0] LO_real;
  logic signed [DW-1:0] LO_imag;
  logic signed [DW-1:0] UO_real;
  logic signed [DW-1:0] UO_imag;
  logic                 sof_err;

  modport master (
    output in_valid, in_sof, LI_real, LI_imag, UI_real, UI_imag,
    input  out_valid, out_sof, LO_real, LO_imag, UO_real, UO_imag, sof_err
  );

  modport slave (
    input  in_valid, in_sof, LI_real, LI_imag, UI_real, UI_imag,
    output out_valid, out_sof, LO_real, LO_imag, UO_real, UO_imag, sof_err
  );

endinterface

// File: rtl/fft8_pingpong_bank.sv
// Two banks of four pair slots; one write port, one asynchronous read port, no reset.
module fft8_pingpong_bank
  import fft8_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  logic  wbank,
  input  addr_t waddr,
  input  pair_t wdata,
  input  logic  rbank,
  input  addr_t raddr,
  output pair_t rdata
);

  pair_t mem [2*N_PAIRS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wbank, waddr}] <= wdata;
    end
  end

  assign rdata = mem[{rbank, raddr}];

endmodule

// File: rtl/fft8_reorder.sv
// Reorders bit-reversed FFT output pairs into natural order using ping-pong banks.
module fft8_reorder
  import fft8_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fft8_reorder_if.slave  bus
);

  logic       sync_q, sync_d;
  addr_t      wcnt_q, wcnt_d;
  logic       wb_q, wb_d;
  logic       rb_q, rb_d;
  logic [1:0] full_q, full_d;
  logic [1:0] full_set, full_clr;
  rd_state_e  state_q, state_d;
  addr_t      rcnt_q, rcnt_d;
  logic       sof_err_q, sof_err_d;

  logic       accept;
  addr_t      wslot;
  pair_t      wdata, rdata;
  logic       rd_en;
  addr_t      rd_addr;

  logic       out_valid_q, out_sof_q;
  pair_t      out_data_q;

  // An in_sof beat always restarts the frame at slot 0, even when unsynced.
  assign accept = bus.in_valid & (sync_q | bus.in_sof);
  assign wslot  = bus.in_sof ? 2'd0 : wcnt_q;
  assign wdata  = '{l_real: bus.LI_real, l_imag: bus.LI_imag,
                    u_real: bus.UI_real, u_imag: bus.UI_imag};

  always_comb begin
    sync_d    = sync_q;
    wcnt_d    = wcnt_q;
    wb_d      = wb_q;
    full_set  = 2'b00;
    sof_err_d = 1'b0;
    if (accept) begin
      sync_d    = 1'b1;
      sof_err_d = bus.in_sof & (wcnt_q != 2'd0);
      if (wslot == 2'd3) begin
        wcnt_d       = 2'd0;
        wb_d         = ~wb_q;
        full_set[wb_q] = 1'b1;
      end else begin
        wcnt_d = wslot + 2'd1;
      end
    end
  end

  fft8_pingpong_bank u_bank (
    .clk   (clk),
    .we    (accept),
    .wbank (wb_q),
    .waddr (br2(wslot)),
    .wdata (wdata),
    .rbank (rb_q),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  // Address 0 is issued from idle so the first output lands two cycles after the last beat.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    rb_d     = rb_q;
    full_clr = 2'b00;
    rd_en    = 1'b0;
    rd_addr  = 2'd0;
    unique case (state_q)
      StIdle: begin
        if (full_q[rb_q]) begin
          rd_en   = 1'b1;
          rd_addr = 2'd0;
          rcnt_d  = 2'd1;
          state_d = StRead;
        end
      end
      StRead: begin
        rd_en   = 1'b1;
        rd_addr = rcnt_q;
        if (rcnt_q == 2'd3) begin
          full_clr[rb_q] = 1'b1;
          rb_d           = ~rb_q;
          rcnt_d         = 2'd0;
          if (!full_q[~rb_q]) begin
            state_d = StIdle;
          end
        end else begin
          rcnt_d = rcnt_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign full_d = (full_q & ~full_clr) | full_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 1'b0;
      wcnt_q      <= 2'd0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      full_q      <= 2'b00;
      state_q     <= StIdle;
      rcnt_q      <= 2'd0;
      sof_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      sync_q      <= sync_d;
      wcnt_q      <= wcnt_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      full_q      <= full_d;
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      sof_err_q   <= sof_err_d;
      out_valid_q <= rd_en;
      out_sof_q   <= rd_en & (rd_addr == 2'd0);
      out_data_q  <= rd_en ? rdata : '0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.LO_real   = out_data_q.l_real;
  assign bus.LO_imag   = out_data_q.l_imag;
  assign bus.UO_real   = out_data_q.u_real;
  assign bus.UO_imag   = out_data_q.u_imag;
  assign bus.sof_err   = sof_err_q;

endmodule

// File: tb/tb_fft8_reorder.sv
// Scoreboard bench for fft8_reorder: directed frames, expected pairs queued at issue time.
module tb_fft8_reorder;
  import fft8_pkg::*;

  typedef struct {
    logic  sof;
    pair_t d;
    int    cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   err_cnt = 0;
  int   err_cyc = -1;
  exp_t q[$];
  exp_t mon_e;
  logic signed [DW-1:0] xr[8];
  logic signed [DW-1:0] xi[8];

  fft8_reorder_if bus ();

  fft8_reorder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Monitor: pops one expectation per out_valid beat; idle outputs must be zero.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.sof_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          mon_e = q.pop_front();
          check("out_sof", 64'(bus.out_sof), 64'(mon_e.sof));
          check("out_data", 64'({bus.LO_real, bus.LO_imag, bus.UO_real, bus.UO_imag}),
                64'(mon_e.d));
          check("out_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end else begin
        check("idle_zero", 64'({bus.out_sof, bus.LO_real, bus.LO_imag, bus.UO_real,
                                bus.UO_imag}), 64'd0);
      end
    end
  end

  task automatic fill_ramp(input int base);
    for (int k = 0; k < 8; k++) begin
      xr[k] = DW'(base + k);
      xi[k] = DW'(-(base + k));
    end
  endtask

  // Drive one beat after the edge; e is the edge count that captures it.
  task automatic drive(input bit v, input bit s, input int p, output int e);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_sof   = s;
    if (p >= 0) begin
      bus.LI_real = xr[2*p];
      bus.LI_imag = xi[2*p];
      bus.UI_real = xr[2*p+1];
      bus.UI_imag = xi[2*p+1];
    end
    e = cyc + 1;
  endtask

  task automatic idle(input int n);
    int e;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, -1, e);
  endtask

  task automatic send(input int nb, input bit sof, input bit gapped, input bit expect_out,
                      output int e_first, output int e_last);
    int e;
    exp_t x;
    e_first = 0;
    e_last  = 0;
    for (int c = 0; c < nb; c++) begin
      drive(1'b1, sof && (c == 0), int'(br2(2'(c))), e);
      if (c == 0) e_first = e;
      e_last = e;
      if (c == 3 && expect_out) begin
        for (int j = 0; j < 4; j++) begin
          x.sof = (j == 0);
          x.d   = '{l_real: xr[2*j], l_imag: xi[2*j], u_real: xr[2*j+1], u_imag: xi[2*j+1]};
          x.cyc = e + 1 + j;
          q.push_back(x);
        end
      end
      if (gapped) idle(1);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int ef, el, ef2, n;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.LI_real  = '0;
    bus.LI_imag  = '0;
    bus.UI_real  = '0;
    bus.UI_imag  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_sof", 64'(bus.out_sof), 64'd0);
    check("reset_sof_err", 64'(bus.sof_err), 64'd0);
    check("reset_data", 64'({bus.LO_real, bus.LO_imag, bus.UO_real, bus.UO_imag}), 64'd0);
    rst = 1'b0;

    // Single frame: LI_real 0,4,2,6 / UI_real 1,5,3,7.
    fill_ramp(0);
    send(4, 1'b1, 1'b0, 1'b1, ef, el);
    idle(1);
    drain("drain_single");

    // Three back-to-back frames.
    for (int k = 0; k < 3; k++) begin
      fill_ramp(100 * (k + 1));
      send(4, 1'b1, 1'b0, 1'b1, ef, el);
    end
    idle(1);
    drain("drain_b2b");

    // Gapped input.
    fill_ramp(300);
    send(4, 1'b1, 1'b1, 1'b1, ef, el);
    fill_ramp(400);
    send(4, 1'b1, 1'b1, 1'b1, ef, el);
    drain("drain_gapped");
    check("no_sof_err_yet", 64'(err_cnt), 64'd0);

    // Truncated frame then a full frame.
    fill_ramp(500);
    send(2, 1'b1, 1'b0, 1'b0, ef, el);
    fill_ramp(600);
    send(4, 1'b1, 1'b0, 1'b1, ef2, el);
    idle(1);
    drain("drain_trunc");
    check("sof_err_count", 64'(err_cnt), 64'd1);
    check("sof_err_cycle", 64'(err_cyc), 64'(ef2));
    err_cnt = 0;

    // Unsynced beats after reset are ignored.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    fill_ramp(700);
    send(4, 1'b0, 1'b0, 1'b0, ef, el);
    idle(10);

    // Reset during output beat 1.
    fill_ramp(800);
    send(4, 1'b1, 1'b0, 1'b1, ef, el);
    idle(1);
    n = 0;
    while (cyc < el + 2 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("beat1_valid", 64'(bus.out_valid), 64'd1);
    check("beat1_lo_real", 64'(bus.LO_real), 64'(DW'(802)));
    rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_sof", 64'(bus.out_sof), 64'd0);
    check("rst_data", 64'({bus.LO_real, bus.LO_imag, bus.UO_real, bus.UO_imag}), 64'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    fill_ramp(900);
    send(4, 1'b0, 1'b0, 1'b0, ef, el);
    idle(10);

    // Extreme values pass bit-exact.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        xr[k] = DW'(-8192);
        xi[k] = DW'(k * 10 + 1);
      end else begin
        xr[k] = DW'(-(k * 10 + 1));
        xi[k] = DW'(8191);
      end
    end
    send(4, 1'b1, 1'b0, 1'b1, ef, el);
    idle(1);
    drain("drain_extreme");
    check("no_sof_err_after_reset", 64'(err_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
